// File: rtl/adc_meas_sched.sv
// Measurement scheduler for the multi-slope ADC: walks the input mux through
// signal/zero/reference conversions and buffers tagged results for the framer.
module adc_meas_sched #(
  parameter int SETTLE_CYC  = 40,
  parameter int TIMEOUT_CYC = 60000,
  parameter int ZERO_EVERY  = 8
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        clr_flags,
  input  logic        conv_done,
  input  logic [31:0] conv_result,
  output logic [1:0]  mux_sel,
  output logic        conv_start,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_tag,
  output logic [7:0]  res_seq,
  output logic        overflow,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, ADVANCE} state_t;

  localparam logic [19:0] SETTLE_LIM = 20'(SETTLE_CYC);
  localparam logic [19:0] TMO_LIM    = 20'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  ZE_LIM     = 8'(ZERO_EVERY);
  localparam logic [1:0]  PH_SIG     = 2'd0;
  localparam logic [1:0]  PH_ZERO    = 2'd1;
  localparam logic [1:0]  PH_REF     = 2'd2;

  state_t      state, next_state;
  logic [19:0] cnt;
  logic [1:0]  phase, next_phase;
  logic [7:0]  sig_cnt, next_sig_cnt;
  logic [7:0]  seq;
  logic        retry;
  logic        done_ev, tmo_ev, load;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run) next_state = SELECT;
      SELECT:  if (cnt == SETTLE_LIM) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (conv_done || cnt == TMO_LIM) next_state = ADVANCE;
      ADVANCE: next_state = run ? SELECT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    conv_start = (state == START);
    busy       = (state != IDLE);
    done_ev    = (state == WAIT) && conv_done;
    tmo_ev     = (state == WAIT) && !conv_done && (cnt == TMO_LIM);
    load       = done_ev && (!res_valid || res_ready);
  end

  // A retried (timed-out) conversion keeps both the phase and the signal count.
  always_comb begin
    next_phase   = phase;
    next_sig_cnt = sig_cnt;
    if (!retry) begin
      case (phase)
        PH_SIG: begin
          if (sig_cnt + 8'd1 == ZE_LIM) begin
            next_sig_cnt = 8'd0;
            next_phase   = PH_ZERO;
          end else begin
            next_sig_cnt = sig_cnt + 8'd1;
          end
        end
        PH_ZERO: next_phase = PH_REF;
        default: next_phase = PH_SIG;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mux_sel <= PH_SIG;
      phase   <= PH_SIG;
      sig_cnt <= '0;
      retry   <= 1'b0;
      seq     <= '0;
    end else begin
      if (state != next_state)                 cnt <= '0;
      else if (state == SELECT || state == WAIT) cnt <= cnt + 20'd1;
      if (state == IDLE && run)    mux_sel <= phase;
      if (state == ADVANCE && run) mux_sel <= next_phase;
      if (state == ADVANCE) begin
        phase   <= next_phase;
        sig_cnt <= next_sig_cnt;
        retry   <= 1'b0;
      end else if (tmo_ev) begin
        retry <= 1'b1;
      end
      if (done_ev) seq <= seq + 8'd1;
    end
  end

  // Single-entry output buffer; a drain and a reload may happen on the same edge.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_seq   <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (load) begin
        res_valid <= 1'b1;
        res_data  <= conv_result;
        res_tag   <= mux_sel;
        res_seq   <= seq + 8'd1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (done_ev && !load) overflow <= 1'b1;
      else if (clr_flags)   overflow <= 1'b0;
      if (tmo_ev)         timeout <= 1'b1;
      else if (clr_flags) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_meas_sched.sv
// Directed bench for adc_meas_sched with a small ADC-core responder and a
// result monitor; expected values are hand-derived for SETTLE=4, TIMEOUT=16, ZERO_EVERY=2.
module tb_adc_meas_sched;

  logic        mclk, rst_n, run, clr_flags, conv_done, res_ready;
  logic [31:0] conv_result;
  logic [1:0]  mux_sel, res_tag;
  logic        conv_start, busy, res_valid, overflow, timeout;
  logic [31:0] res_data;
  logic [7:0]  res_seq;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  t;
    logic [7:0]  s;
  } rec_t;

  rec_t q[$];
  int   start_cyc[$];
  int   start_gap[$];
  int   cyc, last_chg;
  logic [1:0] prev_mux;
  int   vectors, miscompares;
  int   core_en, core_dly;
  logic [31:0] next_result;

  adc_meas_sched #(.SETTLE_CYC(4), .TIMEOUT_CYC(16), .ZERO_EVERY(2)) dut (
    .mclk(mclk), .rst_n(rst_n), .run(run), .clr_flags(clr_flags),
    .conv_done(conv_done), .conv_result(conv_result), .mux_sel(mux_sel),
    .conv_start(conv_start), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .res_seq(res_seq), .overflow(overflow), .timeout(timeout)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  always @(posedge mclk) cyc <= cyc + 1;

  // Monitor: records delivered results, conv_start times and mux_sel changes.
  always @(negedge mclk) begin
    if (rst_n && res_valid && res_ready) q.push_back('{res_data, res_tag, res_seq});
    if (conv_start) begin
      start_cyc.push_back(cyc);
      start_gap.push_back(cyc - last_chg);
    end
    if (mux_sel != prev_mux) begin
      last_chg = cyc;
      prev_mux = mux_sel;
    end
  end

  // ADC core model: answers core_dly cycles after seeing conv_start.
  initial begin
    conv_done   = 1'b0;
    conv_result = '0;
    forever begin
      @(negedge mclk);
      if (conv_start && core_en != 0) begin
        repeat (core_dly) @(posedge mclk);
        #1;
        conv_done   = 1'b1;
        conv_result = next_result;
        next_result = next_result + 32'd1;
        @(posedge mclk);
        #1 conv_done = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyReset();
    @(posedge mclk);
    #1;
    run = 1'b0;
    clr_flags = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    q.delete();
    start_cyc.delete();
    start_gap.delete();
    next_result = 32'h100;
    rst_n = 1'b1;
  endtask

  task automatic waitResults(input string tag, input int n);
    for (int i = 0; i < 300 && q.size() < n; i++) @(negedge mclk);
    checkOutput(tag, q.size(), n);
  endtask

  task automatic waitStart(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (conv_start) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(tag, got, 1);
  endtask

  task automatic stopRun(input string tag);
    @(posedge mclk);
    #1 run = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(negedge mclk);
    checkOutput(tag, busy, 0);
  endtask

  task automatic applyStimulus();
    logic [1:0] exp_tag [5];
    exp_tag = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};

    // Reset state
    core_en = 1; core_dly = 5; res_ready = 1'b1;
    applyReset();
    #2;
    checkOutput("rst_ctl", {busy, conv_start, res_valid, overflow, timeout}, 0);
    checkOutput("rst_mux", mux_sel, 0);
    checkOutput("rst_data", res_data, 0);
    checkOutput("rst_tagseq", {res_tag, res_seq}, 0);

    // Basic sequence
    run = 1'b1;
    waitResults("basic_cnt", 5);
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      checkOutput($sformatf("basic_data%0d", i), q[i].d, 32'h100 + 32'(i));
      checkOutput($sformatf("basic_tag%0d", i), q[i].t, exp_tag[i]);
      checkOutput($sformatf("basic_seq%0d", i), q[i].s, 32'(i + 1));
    end
    if (start_cyc.size() >= 5) begin
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("period%0d", i), start_cyc[i+1] - start_cyc[i], 12);
      for (int i = 2; i < 5; i++)
        checkOutput($sformatf("settle%0d", i), start_gap[i], 5);
    end else begin
      checkOutput("basic_starts", start_cyc.size(), 5);
    end
    stopRun("basic_idle");

    // Backpressure
    applyReset();
    res_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 200 && !overflow; i++) @(negedge mclk);
    checkOutput("bp_ovf", overflow, 1);
    checkOutput("bp_held", {res_valid, res_tag, res_seq}, {1'b1, 2'd0, 8'd1});
    @(posedge mclk);
    #1 res_ready = 1'b1;
    waitResults("bp_cnt", 2);
    if (q.size() >= 2) begin
      checkOutput("bp_first", q[0].s, 1);
      checkOutput("bp_next", {q[1].t, q[1].s}, {2'd1, 8'd3});
    end
    clr_flags = 1'b1;
    @(posedge mclk);
    #1 clr_flags = 1'b0;
    checkOutput("bp_clr", overflow, 0);
    stopRun("bp_idle");

    // Timeout and retry
    applyReset();
    core_en = 0;
    run = 1'b1;
    waitStart("tmo_start");
    repeat (16) @(negedge mclk);
    checkOutput("tmo_early", timeout, 0);
    @(negedge mclk);
    checkOutput("tmo_set", timeout, 1);
    core_en = 1;
    waitResults("tmo_cnt", 1);
    if (q.size() >= 1) checkOutput("tmo_retry", {q[0].t, q[0].s}, {2'd0, 8'd1});
    if (start_cyc.size() >= 2) checkOutput("tmo_restart", start_cyc[1] - start_cyc[0], 23);
    else checkOutput("tmo_starts", start_cyc.size(), 2);
    checkOutput("tmo_sticky", timeout, 1);
    stopRun("tmo_idle");

    // Timeout race: completion on the last WAIT cycle wins
    applyReset();
    core_dly = 16;
    run = 1'b1;
    waitResults("race_cnt", 1);
    if (q.size() >= 1) checkOutput("race_seq", q[0].s, 1);
    checkOutput("race_tmo", timeout, 0);
    stopRun("race_idle");
    core_dly = 5;

    // Run stop during WAIT, then resume
    applyReset();
    run = 1'b1;
    waitStart("stop_start");
    repeat (2) @(posedge mclk);
    #1 run = 1'b0;
    waitResults("stop_cnt", 1);
    if (q.size() >= 1) checkOutput("stop_res", {q[0].t, q[0].s}, {2'd0, 8'd1});
    for (int i = 0; i < 50 && busy; i++) @(negedge mclk);
    checkOutput("stop_busy", busy, 0);
    repeat (20) @(negedge mclk);
    checkOutput("stop_nostart", start_cyc.size(), 1);
    @(posedge mclk);
    #1 run = 1'b1;
    waitResults("resume_cnt", 3);
    if (q.size() >= 3) begin
      checkOutput("resume1", {q[1].t, q[1].s}, {2'd0, 8'd2});
      checkOutput("resume2", {q[2].t, q[2].s}, {2'd1, 8'd3});
    end
    stopRun("resume_idle");

    // Async reset mid-SELECT with a held result
    applyReset();
    res_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge mclk);
    @(negedge mclk);
    checkOutput("ar_pre", {busy, res_valid, conv_start}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_ctl", {busy, conv_start, res_valid, overflow, timeout}, 0);
    checkOutput("ar_data", {res_data, res_tag, res_seq, mux_sel}, 0);
    @(posedge mclk);
    #1;
    q.delete();
    rst_n = 1'b1;
    res_ready = 1'b1;
    waitResults("ar_cnt", 1);
    if (q.size() >= 1) checkOutput("ar_first", {q[0].t, q[0].s}, {2'd0, 8'd1});
    stopRun("ar_idle");
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    cyc = 0; last_chg = 0; prev_mux = 2'd0;
    rst_n = 1'b0; run = 1'b0; clr_flags = 1'b0; res_ready = 1'b1;
    core_en = 1; core_dly = 5; next_result = 32'h100;
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_meas_sched.md
Name: adc_meas_sched

Overview:
- Measurement scheduler placed in front of the multi-slope ADC conversion core.
- Sequences the input mux through signal, zero and reference conversions for autozero/autocal, with a settling delay before each conversion.
- Issues one-cycle conversion starts and enforces a watchdog timeout.
- Hands tagged results to the UART framer over a single-entry valid/ready buffer.

Parameters:
- SETTLE_CYC, 40, mclk cycles mux_sel is held stable before conv_start (valid range 1..65535).
- TIMEOUT_CYC, 60000, mclk cycles to wait for conv_done after conv_start before abort (valid range 2..2^20-1).
- ZERO_EVERY, 8, signal conversions between each ZERO+REF calibration pair (valid range 1..255).

Ports:
- mclk  in  1  system clock; all logic is posedge mclk.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = keep scheduling conversions.
- clr_flags  in  1  one-cycle pulse; clears overflow and timeout.
- conv_done  in  1  one-cycle pulse from the ADC core; conv_result is valid in the same cycle.
- conv_result  in  32  ADC core result word.
- mux_sel  out  2  input select: 0=SIG, 1=ZERO, 2=REF; 3 is never driven.
- conv_start  out  1  one-cycle conversion start pulse.
- busy  out  1  1 in any state other than IDLE.
- res_valid  out  1  output buffer holds a result.
- res_ready  in  1  consumer accepts when res_valid&res_ready.
- res_data  out  32  buffered result.
- res_tag  out  2  mux_sel value used for the buffered result.
- res_seq  out  8  sequence number of the buffered result.
- overflow  out  1  sticky; a result was dropped.
- timeout  out  1  sticky; a conversion timed out.

Behaviour:
- Reset values: mux_sel=0, conv_start=0, busy=0, res_valid=0, res_data=0, res_tag=0, res_seq=0, overflow=0, timeout=0. Reset also clears the internal seq counter, the signal-count counter and the phase, and returns the FSM to IDLE. Reset mid-conversion drops any pending result; stray conv_done pulses are ignored in every state except WAIT.
- FSM states: IDLE, SELECT, START, WAIT, ADVANCE.
- IDLE: when run=1, go to SELECT next cycle; mux_sel takes the current phase on that same edge.
- SELECT: counter counts SETTLE_CYC cycles with mux_sel constant, then go to START.
- START: conv_start=1 for exactly this one cycle, then go to WAIT with the timeout counter at 0.
- WAIT, conv_done=1: capture conv_result, increment the 8-bit seq counter (wraps 255->0), go to ADVANCE.
  - If the buffer is empty, or being drained this cycle (res_valid&res_ready): load res_data, res_tag=mux_sel and res_seq=new seq, with res_valid=1 on the next cycle.
  - Otherwise: drop the result and set overflow. The seq counter still increments, so the gap is visible downstream.
- WAIT, no conv_done: after TIMEOUT_CYC cycles, set timeout, do not increment seq, go to ADVANCE with retry=1. conv_done in the same cycle as the timeout wins; it is treated as completion.
- ADVANCE, one cycle:
  - retry=1: phase is unchanged.
  - Otherwise the phase advances: SIG increments the signal count, and when the count reaches ZERO_EVERY it resets to 0 and the next phase is ZERO. ZERO -> REF. REF -> SIG.
  - Then go to SELECT if run=1, else IDLE.
- Deasserting run never aborts a conversion in progress; the block stops only at ADVANCE. Phase and signal count persist across IDLE.
- Output buffer: res_valid clears on the cycle after the res_valid&res_ready handshake unless it is reloaded in that same cycle. res_data, res_tag and res_seq are stable while res_valid=1 and res_ready=0.
- clr_flags clears overflow and timeout. A set event in the same cycle as clr_flags wins, so the flag stays 1.

Test Plan:
- Basic sequence: SETTLE_CYC=4, TIMEOUT_CYC=16, ZERO_EVERY=2, res_ready=1, core answers 5 cycles after each start with results 0x100, 0x101, ... -> tags SIG, SIG, ZERO, REF, SIG; seq 1, 2, 3, 4, 5; conv_start period is 12 cycles; each conv_start is exactly 5 cycles after mux_sel changes.
- Backpressure: res_ready=0 across two completions -> first result held (seq=1), second dropped, overflow=1; set res_ready=1 -> seq 1 delivered, next delivered result is seq=3; clr_flags -> overflow=0.
- Timeout: withhold conv_done -> timeout=1 exactly 16 cycles after conv_start, seq unchanged, the same mux_sel is retried, and the next conv_start follows SELECT.
- Timeout race: conv_done asserted on the 16th WAIT cycle -> result accepted, timeout stays 0.
- Run stop: drop run during WAIT -> conversion completes, result delivered, FSM returns to IDLE with busy=0; reassert run -> resumes at the next phase in order.
- Async reset: assert rst_n=0 mid-SELECT while res_valid=1 -> all outputs at reset values immediately, independent of mclk; after release with run=1 the first tag is SIG and the first seq is 1.
